lsu_align_split: RTL and testbench

Parametrised load/store alignment unit between the multicycle CPU datapath and a DW-bit byte-enabled memory bus. It generates byte enables and shifts store data into byte lanes. It gathers, right-aligns and sign- or zero-extends load data. When MISALIGN_EN=1 it splits accesses that cross a bus word into two bus beats; when MISALIGN_EN=0 it reports such accesses as errors.

---
 rtl/lsu_align_split_pkg.sv | 50 +++++
 rtl/lsu_lane_gen.sv | 39 +++
 rtl/lsu_align_split.sv | 214 +++++++++++++++++++++
 tb/tb_lsu_align_split.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_align_split_pkg.sv
// Shared encodings for the load/store alignment unit: access sizes, FSM states
// and the load-opcode decode used by the control unit.
package lsu_align_split_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_BEAT0 = 2'b01,
    ST_BEAT1 = 2'b10,
    ST_RESP  = 2'b11
  } lsu_state_e;

  typedef struct packed {
    logic [1:0] size;
    logic       sgn;
  } ld_op_t;

  // funct3 of LB/LH/LW/LD/LBU/LHU/LWU
  function automatic ld_op_t funct3_to_op(input logic [2:0] funct3);
    ld_op_t op;
    case (funct3)
      3'b000:  op = '{size: SZ_B, sgn: 1'b1};
      3'b001:  op = '{size: SZ_H, sgn: 1'b1};
      3'b010:  op = '{size: SZ_W, sgn: 1'b1};
      3'b011:  op = '{size: SZ_D, sgn: 1'b1};
      3'b100:  op = '{size: SZ_B, sgn: 1'b0};
      3'b101:  op = '{size: SZ_H, sgn: 1'b0};
      3'b110:  op = '{size: SZ_W, sgn: 1'b0};
      default: op = '{size: SZ_D, sgn: 1'b0};
    endcase
    return op;
  endfunction

  function automatic logic [3:0] size_bytes(input logic [1:0] sz);
    logic [3:0] n;
    case (sz)
      SZ_B:    n = 4'd1;
      SZ_H:    n = 4'd2;
      SZ_W:    n = 4'd4;
      SZ_D:    n = 4'd8;
      default: n = 4'd1;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/lsu_lane_gen.sv
// Byte-enable and lane-shift generator for one bus beat of a possibly
// word-crossing access. Beat 1 carries the bytes that spill past lane NB-1.
module lsu_lane_gen
  import lsu_align_split_pkg::*;
#(
  parameter int NB = 4,
  parameter int OB = 2
) (
  input  logic [1:0]    size,
  input  logic [OB-1:0] off,
  input  logic          beat,
  output logic [NB-1:0] be,
  output logic [OB:0]   shamt
);

  logic [2*NB-1:0] mask_s;
  logic [2*NB-1:0] span_s;

  // Access mask placed over two consecutive bus words; each beat takes one half.
  always_comb begin
    mask_s = '0;
    case (size)
      SZ_B:    mask_s = (2*NB)'(8'h01);
      SZ_H:    mask_s = (2*NB)'(8'h03);
      SZ_W:    mask_s = (2*NB)'(8'h0F);
      SZ_D:    mask_s = (2*NB)'(8'hFF);
      default: mask_s = '0;
    endcase
    span_s = mask_s << off;
    if (beat) begin
      be    = span_s[2*NB-1:NB];
      shamt = (OB+1)'(NB) - {1'b0, off};
    end else begin
      be    = span_s[NB-1:0];
      shamt = {1'b0, off};
    end
  end

endmodule

// File: rtl/lsu_align_split.sv
// Load/store alignment unit: drives byte-enabled bus beats, splits word-crossing
// accesses into two beats (or flags them) and right-aligns/extends load data.
module lsu_align_split
  import lsu_align_split_pkg::*;
#(
  parameter int DW          = 32,
  parameter int AW          = 32,
  parameter int MISALIGN_EN = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [1:0]    req_size,
  input  logic          req_signed,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW/8-1:0] mem_be,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err
);

  localparam int NB = DW / 8;
  localparam int OB = $clog2(NB);

  lsu_state_e    state_r;
  logic          ready_r;
  logic          we_r;
  logic [1:0]    size_r;
  logic          sgn_r;
  logic [OB-1:0] off_r;
  logic          cross_r;
  logic [DW-1:0] wdata_r;
  logic [DW-1:0] lo_buf_r;

  logic          accept_s;
  logic [OB-1:0] req_off_s;
  logic [4:0]    req_end_s;
  logic          req_cross_s;
  logic          req_legal_s;
  logic [1:0]    lg_size_s;
  logic [OB-1:0] lg_off_s;
  logic          lg_beat_s;
  logic [NB-1:0] lg_be_s;
  logic [OB:0]   lg_sh_s;
  logic [DW-1:0] beat0_wdata_s;
  logic [DW-1:0] beat1_wdata_s;
  logic [DW-1:0] lo_src_s;
  logic [DW-1:0] hi_src_s;
  logic [OB:0]   hi_sh_s;
  logic [DW-1:0] raw_s;
  logic [3:0]    s_bytes_s;
  logic [DW-1:0] keep_s;
  logic          sbit_s;
  logic [DW-1:0] ext_s;

  assign req_ready   = ready_r & ~rst;
  assign accept_s    = req_valid & ready_r;
  assign req_off_s   = req_addr[OB-1:0];
  assign req_end_s   = 5'(req_off_s) + 5'(size_bytes(req_size));
  assign req_cross_s = (req_end_s > 5'(NB));
  assign req_legal_s = (req_size != SZ_D) || (DW == 64);

  // In IDLE the lane generator prepares beat 0 of the incoming request;
  // afterwards it prepares beat 1 of the captured one.
  assign lg_size_s = (state_r == ST_IDLE) ? req_size  : size_r;
  assign lg_off_s  = (state_r == ST_IDLE) ? req_off_s : off_r;
  assign lg_beat_s = (state_r != ST_IDLE);

  lsu_lane_gen #(
    .NB (NB),
    .OB (OB)
  ) u_lane_gen (
    .size  (lg_size_s),
    .off   (lg_off_s),
    .beat  (lg_beat_s),
    .be    (lg_be_s),
    .shamt (lg_sh_s)
  );

  assign beat0_wdata_s = req_wdata << {lg_sh_s, 3'b000};
  assign beat1_wdata_s = wdata_r >> {lg_sh_s, 3'b000};

  // Load gather: the final beat's data is taken straight off the bus so the
  // response can be registered on the acknowledging edge.
  always_comb begin
    if (state_r == ST_BEAT1) begin
      lo_src_s = lo_buf_r;
      hi_src_s = mem_rdata;
    end else begin
      lo_src_s = mem_rdata;
      hi_src_s = '0;
    end
    hi_sh_s   = (OB+1)'(NB) - {1'b0, off_r};
    raw_s     = (lo_src_s >> {off_r, 3'b000}) |
                (cross_r ? (hi_src_s << {hi_sh_s, 3'b000}) : '0);
    s_bytes_s = size_bytes(size_r);
    keep_s    = ~({DW{1'b1}} << {s_bytes_s, 3'b000});
    case (size_r)
      SZ_B:    sbit_s = raw_s[7];
      SZ_H:    sbit_s = raw_s[15];
      SZ_W:    sbit_s = raw_s[31];
      SZ_D:    sbit_s = raw_s[DW-1];
      default: sbit_s = raw_s[DW-1];
    endcase
    ext_s = (raw_s & keep_s) | ((sgn_r && sbit_s) ? ~keep_s : '0);
  end

  // Control FSM with registered bus and response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      ready_r   <= 1'b1;
      we_r      <= 1'b0;
      size_r    <= SZ_B;
      sgn_r     <= 1'b0;
      off_r     <= '0;
      cross_r   <= 1'b0;
      wdata_r   <= '0;
      lo_buf_r  <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            ready_r <= 1'b0;
            we_r    <= req_we;
            size_r  <= req_size;
            sgn_r   <= req_signed;
            off_r   <= req_off_s;
            cross_r <= req_cross_s;
            wdata_r <= req_wdata;
            if (!req_legal_s || (req_cross_s && (MISALIGN_EN == 0))) begin
              state_r   <= ST_RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end else begin
              state_r   <= ST_BEAT0;
              mem_req   <= 1'b1;
              mem_we    <= req_we;
              mem_addr  <= {req_addr[AW-1:OB], {OB{1'b0}}};
              mem_be    <= lg_be_s;
              mem_wdata <= beat0_wdata_s;
            end
          end
        end
        ST_BEAT0: begin
          if (mem_ack) begin
            lo_buf_r <= mem_rdata;
            if (cross_r) begin
              state_r   <= ST_BEAT1;
              mem_addr  <= mem_addr + AW'(NB);
              mem_be    <= lg_be_s;
              mem_wdata <= beat1_wdata_s;
            end else begin
              state_r   <= ST_RESP;
              mem_req   <= 1'b0;
              mem_we    <= 1'b0;
              mem_addr  <= '0;
              mem_be    <= '0;
              mem_wdata <= '0;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b0;
              rsp_rdata <= we_r ? '0 : ext_s;
            end
          end
        end
        ST_BEAT1: begin
          if (mem_ack) begin
            state_r   <= ST_RESP;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= we_r ? '0 : ext_s;
          end
        end
        ST_RESP: begin
          state_r   <= ST_IDLE;
          ready_r   <= 1'b1;
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          rsp_rdata <= '0;
        end
        default: begin
          state_r   <= ST_IDLE;
          ready_r   <= 1'b1;
          mem_req   <= 1'b0;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_align_split.sv
// Directed table-driven bench for lsu_align_split (DW=32), with a second
// instance built with MISALIGN_EN=0 for the error path.
module tb_lsu_align_split;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_valid_nm;
  logic        req_ready, nm_req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        nm_mem_req, nm_mem_we, nm_rsp_valid, nm_rsp_err;
  logic [31:0] nm_mem_addr, nm_mem_wdata, nm_rsp_rdata;
  logic [3:0]  nm_mem_be;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lsu_align_split #(.DW(32), .AW(32), .MISALIGN_EN(1)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  lsu_align_split #(.DW(32), .AW(32), .MISALIGN_EN(0)) u_dut_nm (
    .clk(clk), .rst(rst), .req_valid(req_valid_nm), .req_ready(nm_req_ready),
    .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .mem_req(nm_mem_req),
    .mem_we(nm_mem_we), .mem_addr(nm_mem_addr), .mem_be(nm_mem_be),
    .mem_wdata(nm_mem_wdata), .mem_ack(nm_mem_req), .mem_rdata(32'h0),
    .rsp_valid(nm_rsp_valid), .rsp_rdata(nm_rsp_rdata), .rsp_err(nm_rsp_err)
  );

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd0;
    logic [31:0] rd1;
    int          nbeats;
    logic [31:0] a0;
    logic [3:0]  be0;
    logic [31:0] wd0;
    logic [31:0] a1;
    logic [3:0]  be1;
    logic [31:0] wd1;
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v, input bit chk_b2b);
    int  waits;
    int  nb;
    int  lat;
    bit  got;
    req_we = v.we; req_size = v.size; req_signed = v.sgn;
    req_addr = v.addr; req_wdata = v.wdata; req_valid = 1'b1;
    waits = 0;
    while (!req_ready && waits < 10) begin
      @(posedge clk); #1;
      waits++;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (chk_b2b) check($sformatf("v%0d_b2b_wait", idx), 32'(waits), 32'd1);
    nb = 0; lat = 0; got = 1'b0;
    for (int c = 1; c <= 8 && !got; c++) begin
      if (rsp_valid) begin
        got = 1'b1;
        lat = c;
      end else begin
        if (mem_req) begin
          nb++;
          if (nb == 1) begin
            check($sformatf("v%0d_addr0", idx), mem_addr, v.a0);
            check($sformatf("v%0d_be0", idx), 32'(mem_be), 32'(v.be0));
            if (v.we) check($sformatf("v%0d_wd0", idx), mem_wdata, v.wd0);
            mem_rdata = v.rd0;
          end else if (nb == 2) begin
            check($sformatf("v%0d_addr1", idx), mem_addr, v.a1);
            check($sformatf("v%0d_be1", idx), 32'(mem_be), 32'(v.be1));
            if (v.we) check($sformatf("v%0d_wd1", idx), mem_wdata, v.wd1);
            mem_rdata = v.rd1;
          end else begin
            mem_rdata = 32'h0;
          end
          check($sformatf("v%0d_we", idx), 32'(mem_we), 32'(v.we));
          mem_ack = 1'b1;
        end else begin
          mem_ack = 1'b0;
        end
        @(posedge clk); #1;
      end
    end
    mem_ack = 1'b0;
    check($sformatf("v%0d_rsp_seen", idx), 32'(got), 32'd1);
    check($sformatf("v%0d_latency", idx), 32'(lat), 32'(v.lat));
    check($sformatf("v%0d_nbeats", idx), 32'(nb), 32'(v.nbeats));
    check($sformatf("v%0d_err", idx), 32'(rsp_err), 32'(v.err));
    check($sformatf("v%0d_rdata", idx), rsp_rdata, v.rdata);
  endtask

  task automatic run_nm(input string name, input logic [1:0] size, input logic [31:0] addr);
    bit saw_req;
    bit got;
    req_we = 1'b0; req_size = size; req_signed = 1'b0;
    req_addr = addr; req_wdata = 32'h0;
    check({name, "_ready"}, 32'(nm_req_ready), 32'd1);
    req_valid_nm = 1'b1;
    @(posedge clk); #1;
    req_valid_nm = 1'b0;
    saw_req = 1'b0; got = 1'b0;
    for (int c = 1; c <= 6 && !got; c++) begin
      if (nm_mem_req) saw_req = 1'b1;
      if (nm_rsp_valid) begin
        got = 1'b1;
        check({name, "_err"}, 32'(nm_rsp_err), 32'd1);
        check({name, "_rdata"}, nm_rsp_rdata, 32'h0);
      end else begin
        @(posedge clk); #1;
      end
    end
    check({name, "_rsp_seen"}, 32'(got), 32'd1);
    check({name, "_no_memreq"}, 32'(saw_req), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    bit bad;
    vecs[0]  = '{we:1'b1, size:2'b10, sgn:1'b0, addr:32'h100, wdata:32'hDEADBEEF, rd0:32'h0, rd1:32'h0,
                 nbeats:1, a0:32'h100, be0:4'b1111, wd0:32'hDEADBEEF, a1:32'h0, be1:4'b0000, wd1:32'h0, rdata:32'h0, err:1'b0, lat:2};
    vecs[1]  = '{we:1'b1, size:2'b00, sgn:1'b0, addr:32'h103, wdata:32'h000000A5, rd0:32'h0, rd1:32'h0,
                 nbeats:1, a0:32'h100, be0:4'b1000, wd0:32'hA5000000, a1:32'h0, be1:4'b0000, wd1:32'h0, rdata:32'h0, err:1'b0, lat:2};
    vecs[2]  = '{we:1'b0, size:2'b01, sgn:1'b1, addr:32'h102, wdata:32'h0, rd0:32'h80010000, rd1:32'h0,
                 nbeats:1, a0:32'h100, be0:4'b1100, wd0:32'h0, a1:32'h0, be1:4'b0000, wd1:32'h0, rdata:32'hFFFF8001, err:1'b0, lat:2};
    vecs[3]  = '{we:1'b0, size:2'b01, sgn:1'b0, addr:32'h102, wdata:32'h0, rd0:32'h80010000, rd1:32'h0,
                 nbeats:1, a0:32'h100, be0:4'b1100, wd0:32'h0, a1:32'h0, be1:4'b0000, wd1:32'h0, rdata:32'h00008001, err:1'b0, lat:2};
    vecs[4]  = '{we:1'b0, size:2'b10, sgn:1'b0, addr:32'h0FE, wdata:32'h0, rd0:32'h33445566, rd1:32'h77881122,
                 nbeats:2, a0:32'h0FC, be0:4'b1100, wd0:32'h0, a1:32'h100, be1:4'b0011, wd1:32'h0, rdata:32'h11223344, err:1'b0, lat:3};
    vecs[5]  = '{we:1'b1, size:2'b01, sgn:1'b0, addr:32'h101, wdata:32'h0000BEEF, rd0:32'h0, rd1:32'h0,
                 nbeats:1, a0:32'h100, be0:4'b0110, wd0:32'h00BEEF00, a1:32'h0, be1:4'b0000, wd1:32'h0, rdata:32'h0, err:1'b0, lat:2};
    vecs[6]  = '{we:1'b1, size:2'b10, sgn:1'b0, addr:32'h203, wdata:32'h11223344, rd0:32'h0, rd1:32'h0,
                 nbeats:2, a0:32'h200, be0:4'b1000, wd0:32'h44000000, a1:32'h204, be1:4'b0111, wd1:32'h00112233, rdata:32'h0, err:1'b0, lat:3};
    vecs[7]  = '{we:1'b0, size:2'b00, sgn:1'b1, addr:32'h301, wdata:32'h0, rd0:32'h00008000, rd1:32'h0,
                 nbeats:1, a0:32'h300, be0:4'b0010, wd0:32'h0, a1:32'h0, be1:4'b0000, wd1:32'h0, rdata:32'hFFFFFF80, err:1'b0, lat:2};
    vecs[8]  = '{we:1'b0, size:2'b01, sgn:1'b1, addr:32'h3FF, wdata:32'h0, rd0:32'hAB000000, rd1:32'h000000CD,
                 nbeats:2, a0:32'h3FC, be0:4'b1000, wd0:32'h0, a1:32'h400, be1:4'b0001, wd1:32'h0, rdata:32'hFFFFCDAB, err:1'b0, lat:3};
    vecs[9]  = '{we:1'b0, size:2'b11, sgn:1'b0, addr:32'h100, wdata:32'h0, rd0:32'h0, rd1:32'h0,
                 nbeats:0, a0:32'h0, be0:4'b0000, wd0:32'h0, a1:32'h0, be1:4'b0000, wd1:32'h0, rdata:32'h0, err:1'b1, lat:1};
    vecs[10] = '{we:1'b1, size:2'b10, sgn:1'b0, addr:32'hFFFFFFFE, wdata:32'hCAFEF00D, rd0:32'h0, rd1:32'h0,
                 nbeats:2, a0:32'hFFFFFFFC, be0:4'b1100, wd0:32'hF00D0000, a1:32'h00000000, be1:4'b0011, wd1:32'h0000CAFE, rdata:32'h0, err:1'b0, lat:3};
    vecs[11] = '{we:1'b0, size:2'b10, sgn:1'b1, addr:32'h400, wdata:32'h0, rd0:32'h89ABCDEF, rd1:32'h0,
                 nbeats:1, a0:32'h400, be0:4'b1111, wd0:32'h0, a1:32'h0, be1:4'b0000, wd1:32'h0, rdata:32'h89ABCDEF, err:1'b0, lat:2};

    rst = 1'b1; req_valid = 1'b0; req_valid_nm = 1'b0; req_we = 1'b0;
    req_size = 2'b00; req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    mem_ack = 1'b0; mem_rdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_be", 32'(mem_be), 32'd0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) run_vec(i, vecs[i], i > 0);

    @(posedge clk); #1;
    run_nm("nm_cross", 2'b10, 32'h0FE);
    run_nm("nm_size11", 2'b11, 32'h100);

    // Wait states on both beats of a crossing load, then abort with reset.
    req_we = 1'b0; req_size = 2'b10; req_signed = 1'b0; req_addr = 32'h0FE; req_valid = 1'b1;
    check("stall_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    mem_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("stall0_req_%0d", k), 32'(mem_req), 32'd1);
      check($sformatf("stall0_addr_%0d", k), mem_addr, 32'h0FC);
      check($sformatf("stall0_be_%0d", k), 32'(mem_be), 32'hC);
      check($sformatf("stall0_rsp_%0d", k), 32'(rsp_valid), 32'd0);
      @(posedge clk); #1;
    end
    mem_ack = 1'b1; mem_rdata = 32'h33445566;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("stall1_req_%0d", k), 32'(mem_req), 32'd1);
      check($sformatf("stall1_addr_%0d", k), mem_addr, 32'h100);
      check($sformatf("stall1_be_%0d", k), 32'(mem_be), 32'h3);
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_mem_req", 32'(mem_req), 32'd0);
    check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    check("abort_ready_in_rst", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_ready_after", 32'(req_ready), 32'd1);
    bad = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (rsp_valid || mem_req) bad = 1'b1;
    end
    check("abort_quiet", 32'(bad), 32'd0);

    run_vec(100, vecs[0], 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
